// File: rtl/bpred_table_ctrl.sv
// ---------------------------------------------------------------------------
// bpred_table_ctrl
//
// Purpose:
//   Branch history table controller. Holds 2^IDX_W two-bit saturating
//   predictor entries indexed by PC bits [IDX_W+1:2].
//   - A combinational prediction lookup serves fetch.
//   - A resolved-outcome update serves execute.
//   The table storage has no reset so that it can map onto RAM. After reset,
//   or after a flush, a clear walk writes strong-not-taken into every entry,
//   one entry per cycle.
//
// Entry encoding:
//   00 strong-NT, 01 weak-NT, 11 strong-T, 10 weak-T.
//   The prediction is entry[1].
//
// Optional feature:
//   BPRED_STATS_EN adds saturating update and misprediction counters.
//
// Ports:
//   CLK              clock, all state changes on the rising edge
//   RST              synchronous reset, active-high
//   flush            restart the clear walk (pulse or level)
//   ready            1 once the table is valid (RUN state)
//   lookup_pc        fetch PC to predict
//   predict_taken    combinational prediction for lookup_pc
//   upd_en           resolved branch update valid this cycle
//   upd_pc           PC of the resolved branch
//   upd_taken        actual branch outcome
//   upd_mispredict   misprediction flag, only feeds the statistics
//   stat_updates     (BPRED_STATS_EN) accepted update count, saturating
//   stat_mispredicts (BPRED_STATS_EN) accepted mispredict count, saturating
// ---------------------------------------------------------------------------
module bpred_table_ctrl #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  output logic            ready,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            predict_taken,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic            upd_mispredict
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]     stat_updates,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [IDX_W-1:0] r_clrIdx;
  logic [1:0]       r_table [DEPTH];

  logic [IDX_W-1:0] w_lookIdx;
  logic [IDX_W-1:0] w_updIdx;
  logic [1:0]       w_updCur;
  logic [1:0]       w_updNext;
  logic             w_clrLast;
  logic             w_acceptUpd;
  logic             w_wrEn;
  logic [IDX_W-1:0] w_wrIdx;
  logic [1:0]       w_wrData;
  logic             w_unused;

  assign w_lookIdx   = lookup_pc[IDX_W+1:2];
  assign w_updIdx    = upd_pc[IDX_W+1:2];
  assign w_updCur    = r_table[w_updIdx];
  assign w_clrLast   = (r_clrIdx == {IDX_W{1'b1}});
  assign w_acceptUpd = (r_state == ST_RUN) && upd_en;

`ifdef BPRED_STATS_EN
  assign w_unused = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                      upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0]};
`else
  assign w_unused = ^{lookup_pc[PC_W-1:IDX_W+2], lookup_pc[1:0],
                      upd_pc[PC_W-1:IDX_W+2], upd_pc[1:0], upd_mispredict};
`endif

  // Next value of the entry being updated.
  // Weak-taken falls straight to strong-not-taken on a not-taken outcome.
  always_comb begin
    w_updNext = 2'b00;
    case (w_updCur)
      2'b00:   w_updNext = upd_taken ? 2'b01 : 2'b00;
      2'b01:   w_updNext = upd_taken ? 2'b11 : 2'b00;
      2'b11:   w_updNext = upd_taken ? 2'b11 : 2'b10;
      default: w_updNext = upd_taken ? 2'b11 : 2'b00;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic.
  // A flush in either state (re)starts the walk. The walk leaves CLEAR
  // on the edge that writes the last entry.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (!flush && w_clrLast) begin
          w_stateNext = ST_RUN;
        end
      end
      default: begin
        if (flush) begin
          w_stateNext = ST_CLEAR;
        end
      end
    endcase
  end

  // Output logic.
  // In RUN, an update to the same index bypasses the stored value so fetch
  // sees the post-update prediction. In CLEAR, the prediction is masked to 0
  // because table contents are not yet valid.
  always_comb begin
    ready         = 1'b0;
    predict_taken = 1'b0;
    if (r_state == ST_RUN) begin
      ready = 1'b1;
      if (upd_en && (w_lookIdx == w_updIdx)) begin
        predict_taken = w_updNext[1];
      end else begin
        predict_taken = r_table[w_lookIdx][1];
      end
    end
  end

  // Clear-walk index.
  // Wraps naturally to 0 after the last entry, so it already sits at 0
  // when RUN is entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_clrIdx <= '0;
    end else if (flush) begin
      r_clrIdx <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_clrIdx <= r_clrIdx + 1'b1;
    end
  end

  // Single write port onto the table.
  // The clear walk owns it in CLEAR; accepted updates own it in RUN.
  always_comb begin
    w_wrEn   = 1'b0;
    w_wrIdx  = r_clrIdx;
    w_wrData = 2'b00;
    if (r_state == ST_CLEAR) begin
      w_wrEn = 1'b1;
    end else if (w_acceptUpd) begin
      w_wrEn   = 1'b1;
      w_wrIdx  = w_updIdx;
      w_wrData = w_updNext;
    end
  end

  // Table storage.
  // Deliberately has no reset so that it can be implemented as RAM.
  always_ff @(posedge CLK) begin
    if (w_wrEn) begin
      r_table[w_wrIdx] <= w_wrData;
    end
  end

`ifdef BPRED_STATS_EN
  logic [31:0] r_statUpd;
  logic [31:0] r_statMis;

  // Saturating statistics.
  // Only RST clears them (flush does not). Updates dropped during CLEAR
  // are never counted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_statUpd <= '0;
      r_statMis <= '0;
    end else if (w_acceptUpd) begin
      if (r_statUpd != 32'hFFFF_FFFF) begin
        r_statUpd <= r_statUpd + 32'd1;
      end
      if (upd_mispredict && (r_statMis != 32'hFFFF_FFFF)) begin
        r_statMis <= r_statMis + 32'd1;
      end
    end
  end

  assign stat_updates     = r_statUpd;
  assign stat_mispredicts = r_statMis;
`endif

endmodule

// File: tb/tb_bpred_table_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bpred_table_ctrl
//
// Scoreboard bench for bpred_table_ctrl.
// - Stimulus is driven just after each rising edge.
// - The expected ready/predict (and stats) for that cycle come from a
//   behavioural model that tracks predictor strength per entry and the
//   number of clear cycles left. These expectations are pushed into a queue.
// - A monitor pops and compares on every falling edge.
// Compile with BPRED_STATS_EN to also check the statistics counters.
// ---------------------------------------------------------------------------
module tb_bpred_table_ctrl;

  localparam int IDX_W = 4;
  localparam int PC_W  = 32;
  localparam int DEPTH = 1 << IDX_W;

  logic            CLK = 1'b0;
  logic            RST;
  logic            flush;
  logic            ready;
  logic [PC_W-1:0] lookup_pc;
  logic            predict_taken;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            upd_mispredict;
`ifdef BPRED_STATS_EN
  logic [31:0]     stat_updates;
  logic [31:0]     stat_mispredicts;
`endif

  bpred_table_ctrl #(.IDX_W(IDX_W), .PC_W(PC_W)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .flush          (flush),
    .ready          (ready),
    .lookup_pc      (lookup_pc),
    .predict_taken  (predict_taken),
    .upd_en         (upd_en),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict)
`ifdef BPRED_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cycle;
    bit          expReady;
    bit          expPred;
    int unsigned expUpd;
    int unsigned expMis;
  } exp_t;

  exp_t expQ[$];
  int   compareCount = 0;
  int   failCount    = 0;
  int   cycleNum     = 0;

  // Reference model.
  // Strength 0 = strong-NT, 1 = weak-NT, 2 = weak-T, 3 = strong-T.
  // clearLeft counts the edges still needed before the table is valid.
  int          strength [DEPTH];
  int          clearLeft = DEPTH;
  int unsigned mUpd = 0;
  int unsigned mMis = 0;

  function automatic int idxOf(input logic [PC_W-1:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic int nextStrength(input int s, input bit taken);
    if (taken) begin
      return (s == 0) ? 1 : 3;
    end
    return (s == 3) ? 2 : 0;
  endfunction

  // One cycle of stimulus.
  // Drives the inputs, records the expected outputs for this cycle, advances
  // the model across the coming edge, then waits for that edge.
  task automatic applyStimulus(input bit rst, input bit fl,
                               input logic [PC_W-1:0] lpc, input bit ue,
                               input logic [PC_W-1:0] upc, input bit ut,
                               input bit um);
    exp_t e;
    int   li;
    int   ui;
    RST            = rst;
    flush          = fl;
    lookup_pc      = lpc;
    upd_en         = ue;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_mispredict = um;
    li = idxOf(lpc);
    ui = idxOf(upc);
    e.cycle    = cycleNum;
    e.expReady = (clearLeft == 0);
    e.expPred  = 1'b0;
    if (clearLeft == 0) begin
      if (ue && li == ui) begin
        e.expPred = nextStrength(strength[ui], ut) >= 2;
      end else begin
        e.expPred = strength[li] >= 2;
      end
    end
    e.expUpd = mUpd;
    e.expMis = mMis;
    expQ.push_back(e);
    if (rst) begin
      clearLeft = DEPTH;
      mUpd      = 0;
      mMis      = 0;
    end else if (clearLeft > 0) begin
      if (fl) begin
        clearLeft = DEPTH;
      end else begin
        clearLeft--;
        if (clearLeft == 0) begin
          foreach (strength[i]) strength[i] = 0;
        end
      end
    end else begin
      if (ue) begin
        strength[ui] = nextStrength(strength[ui], ut);
        if (mUpd != 32'hFFFF_FFFF) mUpd++;
        if (um && mMis != 32'hFFFF_FFFF) mMis++;
      end
      if (fl) clearLeft = DEPTH;
    end
    @(posedge CLK);
    #1;
    cycleNum++;
  endtask

  // Comparison of one popped expectation against the live outputs.
  task automatic checkOutput(input exp_t e);
    compareCount++;
    if (ready !== e.expReady) begin
      failCount++;
      $display("[TB] FAIL ready cyc=%0d got=%b exp=%b", e.cycle, ready, e.expReady);
    end
    compareCount++;
    if (predict_taken !== e.expPred) begin
      failCount++;
      $display("[TB] FAIL predict cyc=%0d got=%b exp=%b", e.cycle, predict_taken, e.expPred);
    end
`ifdef BPRED_STATS_EN
    compareCount++;
    if (stat_updates !== e.expUpd) begin
      failCount++;
      $display("[TB] FAIL stat_updates cyc=%0d got=%0d exp=%0d", e.cycle, stat_updates, e.expUpd);
    end
    compareCount++;
    if (stat_mispredicts !== e.expMis) begin
      failCount++;
      $display("[TB] FAIL stat_mispredicts cyc=%0d got=%0d exp=%0d", e.cycle, stat_mispredicts, e.expMis);
    end
`endif
  endtask

  // Monitor: one expectation per cycle, popped mid-cycle.
  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  // Idle cycle that only sets the lookup PC.
  task automatic idleLook(input logic [PC_W-1:0] lpc);
    applyStimulus(1'b0, 1'b0, lpc, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic upd(input logic [PC_W-1:0] upc, input bit ut, input bit um,
                     input logic [PC_W-1:0] lpc);
    applyStimulus(1'b0, 1'b0, lpc, 1'b1, upc, ut, um);
  endtask

  initial begin
    RST = 1'b1; flush = 1'b0; lookup_pc = '0; upd_en = 1'b0;
    upd_pc = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Reset for two cycles, then the 16-cycle walk with random lookups.
    applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h44, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) idleLook($urandom);

    // Two taken updates at 0x40, then lookups including an alias.
    upd(32'h40, 1'b1, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 1'b1, 32'h4);
    idleLook(32'h40);
    idleLook(32'h44);
    idleLook(32'h80);

    // Strong-T -> weak-T -> strong-NT, then weak-T -> strong-T.
    upd(32'h40, 1'b0, 1'b1, 32'h44);
    idleLook(32'h40);
    upd(32'h40, 1'b0, 1'b0, 32'h44);
    idleLook(32'h40);
    upd(32'h40, 1'b1, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 1'b0, 32'h0);
    upd(32'h40, 1'b0, 1'b0, 32'h0);
    upd(32'h40, 1'b1, 1'b0, 32'h40);
    idleLook(32'h40);

    // Same-cycle bypass at 0x48 from weak-NT.
    upd(32'h48, 1'b1, 1'b0, 32'h0);
    upd(32'h48, 1'b1, 1'b0, 32'h48);
    idleLook(32'h48);

    // Flush in RUN with a simultaneous update.
    // Then flush again at clr_idx 9, with an update dropped during CLEAR.
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 32'h4C, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) idleLook($urandom);
    applyStimulus(1'b0, 1'b1, 32'h4C, 1'b1, 32'h4C, 1'b1, 1'b1);
    upd(32'h4C, 1'b1, 1'b1, 32'h4C);
    for (int i = 0; i < DEPTH + 2; i++) idleLook(32'h4C);

    // Randomised traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 39) == 0),
                    {$urandom_range(0, 255), 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)},
                    ($urandom_range(0, 9) < 6),
                    {$urandom_range(0, 255), 4'h0, 6'($urandom_range(0, 63)), 2'($urandom)},
                    1'($urandom), 1'($urandom));
    end

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge CLK);
    #1;
    if (expQ.size() > 0) begin
      failCount++;
      $display("[TB] FAIL drain got=%0d pending exp=0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
